// File: rtl/mdu_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: operation
// encodings, FSM state type and small decode helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // True for the two divide operations.
  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // True for the operations that interpret operands as two's complement.
  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Combinational conditional two's-complement negation: y = en ? -x : x.
// Used to form operand magnitudes and to restore result signs.
module mdu_cond_neg #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic         en,
  output logic [N-1:0] y
);

  assign y = en ? (~x + N'(1)) : x;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle integer multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Operands are captured as magnitudes on start, one result bit is produced
// per CALC cycle in a single shared 2*WIDTH shift register, and signs are
// restored in FIX where hi/lo/div_zero are loaded together with done.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  // Architectural state
  state_e           state_q,    state_d;
  op_e              op_q,       op_d;
  logic             sign_a_q,   sign_a_d;
  logic             sign_b_q,   sign_b_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [W2-1:0]    acc_q,      acc_d;
  logic [WIDTH-1:0] opnd_q,     opnd_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [WIDTH-1:0] hi_q,       hi_d;
  logic [WIDTH-1:0] lo_q,       lo_d;
  logic             div_zero_q, div_zero_d;

  // Start-time operand decode and magnitude formation
  op_e              op_in;
  logic             a_neg_en;
  logic             b_neg_en;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign op_in    = op_e'(op);
  assign a_neg_en = op_is_signed(op_in) & a[WIDTH-1];
  assign b_neg_en = op_is_signed(op_in) & b[WIDTH-1];

  mdu_cond_neg #(.N(WIDTH)) u_neg_a (.x(a), .en(a_neg_en), .y(a_mag));
  mdu_cond_neg #(.N(WIDTH)) u_neg_b (.x(b), .en(b_neg_en), .y(b_mag));

  // One iteration of each algorithm on the shared register
  logic             is_div;
  logic             div_by_zero;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;

  assign is_div      = op_is_div(op_q);
  assign div_by_zero = is_div && (opnd_q == '0);

  // Multiply: acc = {partial product high word, remaining multiplier bits};
  // conditionally add the multiplicand to the high word, then shift right.
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits / quotient bits}; shift left into
  // a WIDTH+1 bit partial remainder and subtract the divisor when it fits.
  // The difference always fits in WIDTH bits because the remainder < divisor.
  assign div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

  // FIX-stage sign correction
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  mdu_cond_neg #(.N(W2))    u_neg_prod (.x(acc_q),
                                        .en(sign_a_q ^ sign_b_q), .y(prod_fix));
  mdu_cond_neg #(.N(WIDTH)) u_neg_quo  (.x(acc_q[WIDTH-1:0]),
                                        .en(sign_a_q ^ sign_b_q), .y(quo_fix));
  mdu_cond_neg #(.N(WIDTH)) u_neg_rem  (.x(acc_q[W2-1:WIDTH]),
                                        .en(sign_a_q),            .y(rem_fix));

  // Next-state and datapath update for the IDLE -> CALC -> FIX -> IDLE sequence
  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      ST_IDLE: begin
        // The done cycle still belongs to the finishing operation, so a
        // start coinciding with done is not taken.
        if (start && !done_q) begin
          op_d     = op_in;
          sign_a_d = a_neg_en;
          sign_b_d = b_neg_en;
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          opnd_d   = b_mag;
          cnt_d    = CW'(WIDTH);
          busy_d   = 1'b1;
          state_d  = ST_CALC;
        end
      end

      ST_CALC: begin
        if (div_by_zero) begin
          // Zero divisor bypasses the iterations; park the dividend magnitude
          // in the remainder half so FIX returns the original a in hi.
          acc_d   = {acc_q[WIDTH-1:0], {WIDTH{1'b1}}};
          state_d = ST_FIX;
        end else begin
          acc_d = is_div ? div_next : mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        if (is_div) begin
          hi_d = rem_fix;
          lo_d = div_by_zero ? {WIDTH{1'b1}} : quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        div_zero_d = div_by_zero;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; a reset mid-operation aborts it
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples the values
    // from before this edge regardless of statement order.
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations on a WIDTH=32 instance, a few WIDTH=8 cases, and reset abort.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // WIDTH=32 instance
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  // WIDTH=8 instance
  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int errors = 0;
  int checks = 0;

  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic void ref32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic edz);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    edz = 1'b0;
    if (o == 2'b00) begin
      p = 64'(sx * sy);
    end else if (o == 2'b01) begin
      p = 64'(x) * 64'(y);
    end else if (y == 32'd0) begin
      edz = 1'b1;
      p   = {x, 32'hFFFF_FFFF};
    end else if (o == 2'b10) begin
      q = sx / sy;
      r = sx % sy;
      p = {r[31:0], q[31:0]};
    end else begin
      p = {x % y, x / y};
    end
    eh = p[63:32];
    el = p[31:0];
  endfunction

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit mid_start, input bit start_at_done);
    logic [31:0] eh, el;
    logic        edz;
    int          n, exp_lat;
    bit          seen;
    ref32(o, x, y, eh, el, edz);
    exp_lat = (o[1] && y == 32'd0) ? 2 : 33;
    @(negedge clk);
    check({tag, ":done_idle"}, 64'(done), 64'(0));
    check({tag, ":hi_hold"}, 64'(hi), 64'(last_hi));
    check({tag, ":lo_hold"}, 64'(lo), 64'(last_lo));
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    check({tag, ":busy"}, 64'(busy), 64'(1));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        if (start_at_done) begin
          start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
        end
      end else if (mid_start && n == 10) begin
        start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
      end
    end
    check({tag, ":latency"}, 64'(n), 64'(exp_lat));
    check({tag, ":hi"}, 64'(hi), 64'(eh));
    check({tag, ":lo"}, 64'(lo), 64'(el));
    check({tag, ":div_zero"}, 64'(div_zero), 64'(edz));
    check({tag, ":busy_at_done"}, 64'(busy), 64'(0));
    last_hi = eh;
    last_lo = el;
    if (start_at_done) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, ":start_at_done_ignored"}, 64'(busy), 64'(0));
    end
  endtask

  task automatic do_op8(input string tag, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y);
    int          sx, sy, q, r, p;
    logic [15:0] e;
    logic        edz;
    int          n;
    bit          seen;
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    edz = 1'b0;
    if (o == 2'b00) begin
      p = sx * sy;
      e = p[15:0];
    end else if (o == 2'b01) begin
      p = int'(x) * int'(y);
      e = p[15:0];
    end else if (y == 8'd0) begin
      edz = 1'b1;
      e   = {x, 8'hFF};
    end else if (o == 2'b10) begin
      q = sx / sy;
      r = sx % sy;
      e = {r[7:0], q[7:0]};
    end else begin
      e = {x % y, x / y};
    end
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = done8;
    end
    check({tag, ":latency"}, 64'(n), 64'((o[1] && y == 8'd0) ? 2 : 9));
    check({tag, ":hi"}, 64'(hi8), 64'(e[15:8]));
    check({tag, ":lo"}, 64'(lo8), 64'(e[7:0]));
    check({tag, ":div_zero"}, 64'(dz8), 64'(edz));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    int          seen_done;

    reset = 1'b1;
    start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset:busy", 64'(busy), 64'(0));
    check("reset:done", 64'(done), 64'(0));
    check("reset:hi", 64'(hi), 64'(0));
    check("reset:lo", 64'(lo), 64'(0));
    check("reset:div_zero", 64'(div_zero), 64'(0));

    // Directed corner cases
    do_op("mult_m3x5",     2'b00, 32'hFFFF_FFFD, 32'd5,         1'b0, 1'b0);
    do_op("multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("mult_m1xm1",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("div_m7_2",      2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    do_op("divu_7_2",      2'b11, 32'd7,         32'd2,         1'b0, 1'b1);
    do_op("divu_by0",      2'b11, 32'd100,       32'd0,         1'b0, 1'b0);
    do_op("mult_clr_dz",   2'b00, 32'd12345,     32'd678,       1'b0, 1'b0);
    do_op("div_neg_by0",   2'b10, 32'h8000_0005, 32'd0,         1'b0, 1'b0);
    do_op("div_min_m1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op("mult_min_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    do_op("div_7_m2",      2'b10, 32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0);

    // Random operations with a bias toward zero and small divisors
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      rx = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 15));
        2:       ry = -32'($urandom_range(1, 15));
        default: ry = $urandom;
      endcase
      do_op($sformatf("rand%0d", i), ro, rx, ry, (i % 5) == 0, (i % 7) == 3);
    end

    // Reset 10 cycles into a multiply aborts it
    do_op("pre_reset", 2'b01, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort:busy", 64'(busy), 64'(0));
    check("abort:done", 64'(done), 64'(0));
    check("abort:hi", 64'(hi), 64'(0));
    check("abort:lo", 64'(lo), 64'(0));
    check("abort:div_zero", 64'(div_zero), 64'(0));
    reset = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort:no_done", 64'(seen_done), 64'(0));
    last_hi = '0;
    last_lo = '0;
    do_op("post_reset", 2'b10, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);

    // Narrow instance
    do_op8("w8_mult_7f_80", 2'b00, 8'h7F, 8'h80);
    do_op8("w8_div_min_m1", 2'b10, 8'h80, 8'hFF);
    do_op8("w8_div_by0",    2'b10, 8'hF3, 8'h00);
    for (int i = 0; i < 6; i++) begin
      do_op8($sformatf("w8_rand%0d", i), 2'($urandom), 8'($urandom),
             8'($urandom_range(1, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
